int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl -- nested, priority-based interrupt controller
//
// Synchronizes N_IRQ raw interrupt lines, latches them as pending requests
// (edge or level mode), and presents the highest-priority enabled request
// that outranks the line currently in service as a registered vector jump
// request to the CPU. Acknowledged lines are pushed onto an in-service stack
// (up to DEPTH deep) and popped again by return-from-interrupt.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   reset     : asynchronous, active-low reset
//   irq       : raw interrupt lines (asynchronous to clk)
//   mask_we   : write strobe for the enable mask
//   mask_d    : new enable mask, bit i = 1 enables line i
//   ack       : CPU loaded vec_addr into its PC this cycle
//   reti      : CPU executes return-from-interrupt this cycle
//   req       : registered request for a vector jump
//   vec_addr  : registered vector address belonging to req
//   int_a     : one-hot line currently in service, zero when none
//   level     : current nesting depth
//   pending   : latched, not yet serviced requests
//   uflow     : one-cycle pulse on reti with an empty stack
// ---------------------------------------------------------------------------
module int_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter int          ADDR_W     = 10,
  parameter int unsigned VEC_BASE   = 10'h3C0,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int          DEPTH      = 4,
  parameter bit          EDGE       = 1'b1,
  localparam int         LW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_d,
  input  logic              ack,
  input  logic              reti,
  output logic              req,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [N_IRQ-1:0]  int_a,
  output logic [LW-1:0]     level,
  output logic [N_IRQ-1:0]  pending,
  output logic              uflow
);

  localparam int IW = $clog2(N_IRQ);

  logic [N_IRQ-1:0]  sync1_reg;
  logic [N_IRQ-1:0]  sync2_reg;
  logic [N_IRQ-1:0]  mask_reg;
  logic [N_IRQ-1:0]  pending_reg;
  logic [N_IRQ-1:0]  pend_vis;
  logic [N_IRQ-1:0]  prio_ok;
  logic [N_IRQ-1:0]  cand_vec;
  logic [N_IRQ-1:0]  int_a_reg;
  logic [IW-1:0]     stack_reg [DEPTH];
  logic [LW-1:0]     level_reg;
  logic              req_reg;
  logic              uflow_reg;
  logic [ADDR_W-1:0] vec_addr_reg;
  logic [IW-1:0]     vec_idx_reg;

  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     below_idx;
  logic [IW-1:0]     cand_idx;
  logic              cand_valid;
  logic              room;
  logic              ack_take;
  logic              reti_take;
  logic              pop;
  logic              req_next;
  logic [31:0]       vec_full;
  logic [ADDR_W-1:0] vec_addr_next;

  function automatic logic [N_IRQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_IRQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Two-flop synchronizer on every raw line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
    end
  end

  // An ack only counts while a request is actually being presented; a
  // simultaneous reti is then dropped.
  assign ack_take  = ack & req_reg;
  assign reti_take = reti & ~ack_take;
  assign pop       = reti_take & (level_reg != '0);
  assign room      = int'(level_reg) < DEPTH;

  generate
    if (EDGE) begin : g_edge
      logic [N_IRQ-1:0] prev_reg;
      logic [N_IRQ-1:0] ack_clr;

      assign ack_clr = ack_take ? onehot(vec_idx_reg) : '0;

      // A fresh edge wins over the ack clear so a re-trigger coinciding
      // with the ack is not lost.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_reg    <= '0;
          pending_reg <= '0;
        end else begin
          prev_reg    <= sync2_reg;
          pending_reg <= (pending_reg & ~ack_clr) | (sync2_reg & ~prev_reg);
        end
      end

      assign pend_vis = pending_reg;
    end else begin : g_level
      logic [N_IRQ-1:0] in_stack;

      always_comb begin
        in_stack = '0;
        for (int d = 0; d < DEPTH; d++) begin
          if (d < int'(level_reg)) in_stack[stack_reg[d]] = 1'b1;
        end
      end

      // Registered copy keeps the same request latency as edge mode.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending_reg <= '0;
        else        pending_reg <= sync2_reg;
      end

      assign pend_vis = pending_reg & ~in_stack;
    end
  endgenerate

  // Top of stack and the entry beneath it (the new top after a pop).
  always_comb begin
    top_idx   = '0;
    below_idx = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (int'(level_reg) == d + 1) top_idx   = stack_reg[d];
      if (int'(level_reg) == d + 2) below_idx = stack_reg[d];
    end
  end

  // A line may preempt only if strictly higher priority (lower index) than
  // the line in service; with an empty stack every line qualifies.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_prio
      assign prio_ok[gi] = (level_reg == '0) || (gi < int'(top_idx));
    end
  endgenerate

  assign cand_vec   = pend_vis & mask_reg & prio_ok;
  assign cand_valid = |cand_vec;

  always_comb begin
    cand_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand_vec[i]) cand_idx = IW'(i);
    end
  end

  assign req_next      = cand_valid & room & ~ack_take;
  assign vec_full      = VEC_BASE + 32'(cand_idx) * VEC_STRIDE;
  assign vec_addr_next = vec_full[ADDR_W-1:0];

  // The index pushed on ack is the one registered with vec_addr, i.e. the
  // vector the CPU actually jumped to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg     <= '0;
      level_reg    <= '0;
      int_a_reg    <= '0;
      req_reg      <= 1'b0;
      uflow_reg    <= 1'b0;
      vec_addr_reg <= '0;
      vec_idx_reg  <= '0;
      for (int d = 0; d < DEPTH; d++) stack_reg[d] <= '0;
    end else begin
      if (mask_we) mask_reg <= mask_d;

      req_reg <= req_next;
      if (req_next) begin
        vec_addr_reg <= vec_addr_next;
        vec_idx_reg  <= cand_idx;
      end

      uflow_reg <= reti_take && (level_reg == '0);

      if (ack_take) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (int'(level_reg) == d) stack_reg[d] <= vec_idx_reg;
        end
        level_reg <= level_reg + LW'(1);
        int_a_reg <= onehot(vec_idx_reg);
      end else if (pop) begin
        level_reg <= level_reg - LW'(1);
        int_a_reg <= (level_reg > LW'(1)) ? onehot(below_idx) : '0;
      end
    end
  end

  assign req      = req_reg;
  assign vec_addr = vec_addr_reg;
  assign int_a    = int_a_reg;
  assign level    = level_reg;
  assign pending  = pend_vis;
  assign uflow    = uflow_reg;

endmodule
